// File: rtl/ser_frame_ctrl.sv
// Sequencer for the codec's external 9-bit load/shift register: accepts a word over
// valid/ready, loads it, then shifts it out MSB first with serial clock and frame strobe.
module ser_frame_ctrl #(
   parameter int unsigned WIDTH   = 9,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned GAP     = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Tx_Data,
   input  logic             Tx_Valid,
   output logic             Tx_Ready,
   output logic             Busy,
   output logic             Done,
   output logic             Reg_Load,
   output logic             Reg_Shift_En,
   output logic [WIDTH-1:0] Reg_D,
   input  logic             Reg_Shift_Out,
   output logic             Ser_Clk,
   output logic             Ser_Data,
   output logic             Ser_Frame
);

   localparam int unsigned DIV_W    = $clog2(CLK_DIV);
   localparam int unsigned BIT_W    = $clog2(WIDTH);
   localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             done_q, done_d;

   logic accept_c;
   logic div_last_c;
   logic bit_last_c;
   logic gap_last_c;

   assign accept_c   = Tx_Valid && (state_q == S_IDLE) && !Reset;
   assign div_last_c = (div_q == DIV_LAST);
   assign bit_last_c = (bit_q == BIT_LAST);
   assign gap_last_c = (gap_q == GAP_END);

   // State and counter registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
      end
   end

   // Next-state and counter sequencing
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            div_d = '0;
            bit_d = '0;
            gap_d = '0;
            if (accept_c) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (div_last_c) begin
               div_d = '0;
               if (bit_last_c) begin
                  done_d  = 1'b1;
                  bit_d   = '0;
                  state_d = (GAP > 0) ? S_GAP : S_IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_GAP: begin
            if (div_last_c) begin
               div_d = '0;
               if (gap_last_c) begin
                  gap_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            div_d   = '0;
            bit_d   = '0;
            gap_d   = '0;
         end
      endcase
   end

   // Handshake outputs pass through on the accept cycle; the rest decode registered state
   assign Tx_Ready     = (state_q == S_IDLE);
   assign Busy         = (state_q != S_IDLE);
   assign Done         = done_q;
   assign Reg_Load     = accept_c;
   assign Reg_D        = accept_c ? Tx_Data : '0;
   assign Ser_Frame    = (state_q == S_SHIFT);
   assign Ser_Clk      = Ser_Frame && (div_q >= DIV_HALF);
   assign Reg_Shift_En = Ser_Frame && div_last_c && !bit_last_c;
   assign Ser_Data     = Ser_Frame && Reg_Shift_Out;

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Bench for ser_frame_ctrl: three configurations against a cycle-arithmetic frame model,
// with directed frames pinned by literal expectations followed by random traffic.
module tb_ser_frame_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic        reset    [3];
   logic        tx_valid [3];
   logic [15:0] tx_data  [3];
   logic        tx_ready [3];
   logic        busy     [3];
   logic        done     [3];
   logic        load     [3];
   logic        shen     [3];
   logic        sclk     [3];
   logic        sdata    [3];
   logic        sframe   [3];
   logic        sout     [3];
   logic [15:0] rd       [3];
   logic [15:0] sr       [3];

   logic [8:0] rd0;
   logic [8:0] rd1;
   logic [1:0] rd2;

   assign rd[0] = {7'd0, rd0};
   assign rd[1] = {7'd0, rd1};
   assign rd[2] = {14'd0, rd2};

   ser_frame_ctrl #(.WIDTH(9), .CLK_DIV(4), .GAP(1)) u0 (
      .Clk(clk), .Reset(reset[0]), .Tx_Data(tx_data[0][8:0]), .Tx_Valid(tx_valid[0]),
      .Tx_Ready(tx_ready[0]), .Busy(busy[0]), .Done(done[0]), .Reg_Load(load[0]),
      .Reg_Shift_En(shen[0]), .Reg_D(rd0), .Reg_Shift_Out(sout[0]), .Ser_Clk(sclk[0]),
      .Ser_Data(sdata[0]), .Ser_Frame(sframe[0]));

   ser_frame_ctrl #(.WIDTH(9), .CLK_DIV(4), .GAP(0)) u1 (
      .Clk(clk), .Reset(reset[1]), .Tx_Data(tx_data[1][8:0]), .Tx_Valid(tx_valid[1]),
      .Tx_Ready(tx_ready[1]), .Busy(busy[1]), .Done(done[1]), .Reg_Load(load[1]),
      .Reg_Shift_En(shen[1]), .Reg_D(rd1), .Reg_Shift_Out(sout[1]), .Ser_Clk(sclk[1]),
      .Ser_Data(sdata[1]), .Ser_Frame(sframe[1]));

   ser_frame_ctrl #(.WIDTH(2), .CLK_DIV(2), .GAP(1)) u2 (
      .Clk(clk), .Reset(reset[2]), .Tx_Data(tx_data[2][1:0]), .Tx_Valid(tx_valid[2]),
      .Tx_Ready(tx_ready[2]), .Busy(busy[2]), .Done(done[2]), .Reg_Load(load[2]),
      .Reg_Shift_En(shen[2]), .Reg_D(rd2), .Reg_Shift_Out(sout[2]), .Ser_Clk(sclk[2]),
      .Ser_Data(sdata[2]), .Ser_Frame(sframe[2]));

   function automatic int pw(input int i);
      return (i == 2) ? 2 : 9;
   endfunction
   function automatic int pd(input int i);
      return (i == 2) ? 2 : 4;
   endfunction
   function automatic int pg(input int i);
      return (i == 1) ? 0 : 1;
   endfunction
   function automatic logic [15:0] pmask(input int i);
      return 16'((32'd1 << pw(i)) - 32'd1);
   endfunction

   // External load/shift register the controller drives
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (load[i]) sr[i] <= rd[i];
         else if (shen[i]) sr[i] <= sr[i] << 1;
      end
   end
   assign sout[0] = sr[0][8];
   assign sout[1] = sr[1][8];
   assign sout[2] = sr[2][1];

   task automatic check(input string nm, input int i, input logic [15:0] act,
                        input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
      end
   endtask

   // Model: each frame is described only by its accept cycle and word
   bit mvalid    [3] = '{0, 0, 0};
   int start_c   [3];
   int idle_from [3];
   int done_at   [3];
   logic [15:0] word [3];

   task automatic model_cycle(input int i);
      int w = pw(i);
      int d = pd(i);
      int g = pg(i);
      int t, k, ph;
      logic e_ready = 0, e_busy = 0, e_load = 0, e_shen = 0;
      logic e_clk = 0, e_frame = 0, e_data = 0, e_done = 0;
      logic [15:0] e_d = '0;
      if (mvalid[i]) begin
         e_done = (cyc == done_at[i]);
         if (cyc >= idle_from[i]) begin
            e_ready = 1'b1;
            e_load  = tx_valid[i] && !reset[i];
            e_d     = e_load ? (tx_data[i] & pmask(i)) : 16'd0;
         end else begin
            e_busy = 1'b1;
            t = cyc - start_c[i];
            if (t >= 1 && t <= w * d) begin
               k       = (t - 1) / d;
               ph      = (t - 1) % d;
               e_frame = 1'b1;
               e_clk   = (ph >= d / 2);
               e_shen  = (ph == d - 1) && (k < w - 1);
               e_data  = word[i][w-1-k];
            end
         end
         check("tx_ready", i, 16'(tx_ready[i]), 16'(e_ready));
         check("busy",     i, 16'(busy[i]),     16'(e_busy));
         check("done",     i, 16'(done[i]),     16'(e_done));
         check("reg_load", i, 16'(load[i]),     16'(e_load));
         check("reg_d",    i, rd[i],            e_d);
         check("shift_en", i, 16'(shen[i]),     16'(e_shen));
         check("ser_clk",  i, 16'(sclk[i]),     16'(e_clk));
         check("ser_frame",i, 16'(sframe[i]),   16'(e_frame));
         check("ser_data", i, 16'(sdata[i]),    16'(e_data));
         if (!reset[i] && e_load) begin
            start_c[i]   = cyc;
            word[i]      = tx_data[i] & pmask(i);
            idle_from[i] = cyc + w * d + g * d + 1;
            done_at[i]   = cyc + w * d + 1;
         end
      end
      if (reset[i]) begin
         mvalid[i]    = 1'b1;
         idle_from[i] = cyc + 1;
         done_at[i]   = -1;
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) model_cycle(i);
   end

   task automatic rand_phase(input int i, input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk); #1;
         reset[i]    = ($urandom_range(0, 249) == 0);
         tx_valid[i] = ($urandom_range(0, 2) == 0);
         tx_data[i]  = 16'($urandom) & pmask(i);
      end
      @(posedge clk); #1;
      reset[i]    = 1'b0;
      tx_valid[i] = 1'b0;
   endtask

   // Single frame of 1A5, busy rejection of a held second word, then mid-frame reset
   task automatic run0();
      int c0, nshen, first_shen, nbits, nbusy_load, ndone;
      logic [15:0] bits;
      logic prev;
      @(posedge clk); #1;
      tx_valid[0] = 1'b1;
      tx_data[0]  = 16'h1A5;
      c0 = cyc;
      nshen = 0; first_shen = -1; nbits = 0; nbusy_load = 0; bits = '0; prev = 1'b0;
      for (int j = 0; j <= 41; j++) begin
         @(negedge clk);
         if (shen[0]) begin
            nshen++;
            if (first_shen < 0) first_shen = j;
         end
         if (sclk[0] && !prev) begin
            bits = {bits[14:0], sdata[0]};
            nbits++;
         end
         prev = sclk[0];
         if (j >= 1 && j <= 40 && load[0]) nbusy_load++;
         if (j == 0)  check("lit_load_c0", 0, 16'(load[0]), 16'd1);
         if (j == 36) check("lit_frame_c36", 0, 16'(sframe[0]), 16'd1);
         if (j == 37) begin
            check("lit_frame_c37", 0, 16'(sframe[0]), 16'd0);
            check("lit_done_c37", 0, 16'(done[0]), 16'd1);
         end
         if (j == 40) check("lit_ready_c40", 0, 16'(tx_ready[0]), 16'd0);
         if (j == 41) begin
            check("lit_ready_c41", 0, 16'(tx_ready[0]), 16'd1);
            check("lit_load_c41", 0, 16'(load[0]), 16'd1);
            check("lit_d_c41", 0, rd[0], 16'h0F3);
         end
         @(posedge clk); #1;
         if (j == 0)  tx_data[0]  = 16'h0F3;
         if (j == 41) tx_valid[0] = 1'b0;
      end
      check("lit_shift_cnt", 0, 16'(nshen), 16'd8);
      check("lit_first_shift", 0, 16'(first_shen), 16'd4);
      check("lit_bit_cnt", 0, 16'(nbits), 16'd9);
      check("lit_bits", 0, bits, 16'h1A5);
      check("lit_busy_reject", 0, 16'(nbusy_load), 16'd0);
      repeat (45) @(posedge clk);
      #1;
      tx_valid[0] = 1'b1;
      tx_data[0]  = 16'($urandom) & 16'h1FF;
      c0 = cyc;
      @(posedge clk); #1;
      tx_valid[0] = 1'b0;
      while (cyc < c0 + 15) begin
         @(posedge clk); #1;
      end
      reset[0] = 1'b1;
      @(posedge clk); #1;
      reset[0] = 1'b0;
      @(negedge clk);
      check("rst_frame", 0, 16'(sframe[0]), 16'd0);
      check("rst_clk", 0, 16'(sclk[0]), 16'd0);
      check("rst_shift", 0, 16'(shen[0]), 16'd0);
      check("rst_ready", 0, 16'(tx_ready[0]), 16'd1);
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done[0]) ndone++;
      end
      check("rst_no_done", 0, 16'(ndone), 16'd0);
      rand_phase(0, 400);
   endtask

   // Back-to-back frames with no gap
   task automatic run1();
      int c1;
      @(posedge clk); #1;
      tx_valid[1] = 1'b1;
      tx_data[1]  = 16'h000;
      c1 = cyc;
      for (int j = 0; j <= 38; j++) begin
         @(negedge clk);
         if (j == 36) check("b2b_frame_c36", 1, 16'(sframe[1]), 16'd1);
         if (j == 37) begin
            check("b2b_done_c37", 1, 16'(done[1]), 16'd1);
            check("b2b_load_c37", 1, 16'(load[1]), 16'd1);
            check("b2b_frame_c37", 1, 16'(sframe[1]), 16'd0);
            check("b2b_d_c37", 1, rd[1], 16'h1FF);
         end
         if (j == 38) check("b2b_frame_c38", 1, 16'(sframe[1]), 16'd1);
         @(posedge clk); #1;
         if (j == 0)  tx_data[1]  = 16'h1FF;
         if (j == 37) tx_valid[1] = 1'b0;
      end
      repeat (40) @(posedge clk);
      rand_phase(1, 500);
   endtask

   // Smallest legal configuration
   task automatic run2();
      int nshen, nframe, nbits;
      logic [15:0] bits;
      logic prev;
      @(posedge clk); #1;
      tx_valid[2] = 1'b1;
      tx_data[2]  = 16'h2;
      nshen = 0; nframe = 0; nbits = 0; bits = '0; prev = 1'b0;
      for (int j = 0; j <= 7; j++) begin
         @(negedge clk);
         if (shen[2]) nshen++;
         if (sframe[2]) nframe++;
         if (sclk[2] && !prev) begin
            bits = {bits[14:0], sdata[2]};
            nbits++;
         end
         prev = sclk[2];
         if (j == 5) check("w2_done_c5", 2, 16'(done[2]), 16'd1);
         if (j == 7) check("w2_ready_c7", 2, 16'(tx_ready[2]), 16'd1);
         @(posedge clk); #1;
         if (j == 0) tx_valid[2] = 1'b0;
      end
      check("w2_frame_len", 2, 16'(nframe), 16'd4);
      check("w2_shift_cnt", 2, 16'(nshen), 16'd1);
      check("w2_bit_cnt", 2, 16'(nbits), 16'd2);
      check("w2_bits", 2, bits, 16'h2);
      rand_phase(2, 500);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         reset[i]    = 1'b1;
         tx_valid[i] = 1'b1;
         tx_data[i]  = 16'h1FF & pmask(i);
      end
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         if (r > 0) begin
            for (int i = 0; i < 3; i++) begin
               check("rst_no_load", i, 16'(load[i]), 16'd0);
               check("rst_busy", i, 16'(busy[i]), 16'd0);
            end
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         reset[i]    = 1'b0;
         tx_valid[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) check("rel_ready", i, 16'(tx_ready[i]), 16'd1);
      fork
         run0();
         run1();
         run2();
      join
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ser_frame_ctrl.md
Name: ser_frame_ctrl

Overview:
Sequencing controller for the 9-bit load/shift register (Load, Shift_En, D[8:0], Shift_Out = MSB) used to serialize control and sample words to the audio codec. It accepts a parallel word from a requester over a valid/ready handshake and loads it into the external shift register. It then steps the register one bit per serial-clock period, MSB first, and generates the serial clock and frame strobe. It sits between the playback/config logic and the codec pins, and owns the shift register exclusively.

Parameters:
WIDTH, 9, word length in bits; matches the shift register width; legal range 2..16.
CLK_DIV, 4, system clocks per serial bit; even, >= 2.
GAP, 1, idle serial-bit periods inserted after each frame; legal range 0..15.

Ports:
Clk  in  1  system clock, all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Tx_Data  in  WIDTH  word to transmit; sampled on the accept cycle.
Tx_Valid  in  1  requester has a word.
Tx_Ready  out  1  controller can accept; high only in IDLE.
Busy  out  1  high in any state other than IDLE.
Done  out  1  one-cycle pulse when the last bit period completes.
Reg_Load  out  1  drives the shift register Load.
Reg_Shift_En  out  1  drives the shift register Shift_En.
Reg_D  out  WIDTH  drives the shift register D.
Reg_Shift_Out  in  1  shift register MSB (Shift_Out).
Ser_Clk  out  1  serial clock to codec.
Ser_Data  out  1  serial data to codec.
Ser_Frame  out  1  high while frame bits are on Ser_Data.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (Clk, Reset). Reset forces IDLE, clears all counters, and drives Tx_Ready=1, Busy=0, Done=0, Reg_Load=0, Reg_Shift_En=0, Ser_Clk=0, Ser_Frame=0, Ser_Data=0 from the next cycle. Reset mid-frame aborts the frame with no Done pulse. Reset has priority over everything.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Tx_Ready=1.
  - Accept cycle T is any cycle with Tx_Valid&Tx_Ready.
  - In cycle T, Reg_Load=1 (combinational from handshake) and Reg_D=Tx_Data (pass-through), so the register holds the word from T+1.
  - Next state is SHIFT.
  - Reg_D is don't-care outside the accept cycle; it is driven 0.
- SHIFT:
  - Lasts WIDTH*CLK_DIV cycles (T+1 .. T+WIDTH*CLK_DIV).
  - A bit counter runs 0..WIDTH-1 and a divider counter runs 0..CLK_DIV-1.
  - Bit k occupies cycles T+1+k*CLK_DIV .. T+(k+1)*CLK_DIV.
  - Ser_Clk=0 for the first CLK_DIV/2 cycles of each bit period and 1 for the second half. The codec samples on the rising edge.
  - Reg_Shift_En=1 on the last cycle of bit periods k=0..WIDTH-2 only. There is never a shift after the last bit.
  - Ser_Frame=1 throughout SHIFT.
  - Ser_Data=Reg_Shift_Out while Ser_Frame=1, else 0.
- End of frame: on the cycle after the last bit period, Done=1 for exactly one cycle.
  - If GAP>0: enter GAP for GAP*CLK_DIV cycles. Ser_Clk=0, Ser_Frame=0, Busy=1. Done fires on the first GAP cycle. Then go to IDLE.
  - If GAP=0: go directly to IDLE. Done fires on the first IDLE cycle. A new word may be accepted in that same cycle, giving back-to-back frames.
- Tx_Valid outside IDLE is ignored. Tx_Data need not be held after acceptance.
- Reg_Load and Reg_Shift_En are never high in the same cycle.
- Ser_Clk, Ser_Frame, Busy and Tx_Ready decode only from registered state and counters; they are glitch-free w.r.t. inputs.
- Counter widths: $clog2 of the respective ranges. The divider wraps CLK_DIV-1 -> 0. The bit counter saturates at WIDTH-1 until the state change.

Test Plan:
- Reset values: assert Reset 3 cycles, drive Tx_Valid=1 during reset -> all outputs at their reset values, no Reg_Load, Tx_Ready=1 after release.
- Single frame (WIDTH=9, CLK_DIV=4, GAP=1), Tx_Data=9'h1A5, accept at cycle 0:
  - Reg_Load=1 at cycle 0 only.
  - Ser_Frame=1 for cycles 1..36.
  - Reg_Shift_En pulses at cycles 4,8,...,32 (8 pulses).
  - Ser_Clk high at cycles 3-4, 7-8, ...
  - Ser_Data sampled at rising edges = 1,1,0,1,0,0,1,0,1.
  - Done at cycle 37; Tx_Ready returns at cycle 41.
- Busy rejection: Tx_Valid held high with a new word during cycles 1..40 -> no second Reg_Load before cycle 41; the second word is accepted at cycle 41.
- Back-to-back with GAP=0: two words 9'h000, 9'h1FF -> second Reg_Load in the same cycle as the first Done; Ser_Frame low for exactly 1 cycle between frames.
- Reset mid-frame: Reset at cycle 15 of a frame -> Ser_Frame/Ser_Clk/Reg_Shift_En low from cycle 16, no Done, Tx_Ready=1 from cycle 16; the next frame transmits correctly.
- Parameter sweep: CLK_DIV=2, WIDTH=2, Tx_Data=2'b10 -> frame lasts 4 cycles, exactly one Reg_Shift_En pulse, Ser_Data bits = 1,0.
